// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - md_op encodings (MD_NONE..MD_MSUB), operation code width MD_OP_W
//   - default busy-cycle counts for multiply and divide
//   - FSM state type and a small decode helper
package mdu_pkg;

  localparam int unsigned MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd8;
  localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd9;
  localparam logic [MD_OP_W-1:0] MD_MSUB  = 4'd10;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } mdu_state_e;

  function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_compute.sv
// mdu_compute: combinational 64-bit result for the multi-cycle MDU operations.
// Ports:
//   i_op     operation code (mdu_pkg encodings)
//   i_a/i_b  rs / rt operands
//   i_hi/i_lo current HI/LO (accumulator input and value kept on divide by zero)
//   o_result {HI,LO} result
//   o_keep   divide by zero: HI/LO must not be written at commit
// Optional feature: MDU_MADD_EN adds MADD/MSUB ({HI,LO} +/- signed product).
module mdu_compute
  import mdu_pkg::*;
(
  input  logic [MD_OP_W-1:0] i_op,
  input  logic [31:0]        i_a,
  input  logic [31:0]        i_b,
  input  logic [31:0]        i_hi,
  input  logic [31:0]        i_lo,
  output logic [63:0]        o_result,
  output logic               o_keep
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_mag_safe;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;
  logic        w_b_zero;

  always_comb begin
    w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide done on magnitudes; 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 with no special case.
    w_b_zero     = (i_b == 32'd0);
    w_a_mag      = i_a[31] ? -i_a : i_a;
    w_b_mag      = i_b[31] ? -i_b : i_b;
    w_b_mag_safe = w_b_zero ? 32'd1 : w_b_mag;
    w_b_safe     = w_b_zero ? 32'd1 : i_b;
    w_q_mag      = w_a_mag / w_b_mag_safe;
    w_r_mag      = w_a_mag % w_b_mag_safe;
    w_q_s        = (i_a[31] ^ i_b[31]) ? -w_q_mag : w_q_mag;
    w_r_s        = i_a[31] ? -w_r_mag : w_r_mag;
    w_q_u        = i_a / w_b_safe;
    w_r_u        = i_a % w_b_safe;
  end

  always_comb begin
    o_result = {i_hi, i_lo};
    o_keep   = 1'b0;
    case (i_op)
      MD_MULT:  o_result = w_prod_s;
      MD_MULTU: o_result = w_prod_u;
      MD_DIV: begin
        if (w_b_zero) o_keep = 1'b1;
        else          o_result = {w_r_s, w_q_s};
      end
      MD_DIVU: begin
        if (w_b_zero) o_keep = 1'b1;
        else          o_result = {w_r_u, w_q_u};
      end
`ifdef MDU_MADD_EN
      MD_MADD:  o_result = {i_hi, i_lo} + w_prod_s;
      MD_MSUB:  o_result = {i_hi, i_lo} - w_prod_s;
`endif
      default:  o_result = {i_hi, i_lo};
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit beside the E-stage ALU.
// Owns HI/LO. MULT/MULTU/DIV/DIVU (and MADD/MSUB with MDU_MADD_EN) compute the
// result at issue into pending registers and commit after a fixed busy window;
// MTHI/MTLO write immediately; MFHI/MFLO read combinationally.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset (clears HI, LO, counter, busy)
//   start     op valid in E this cycle
//   md_op     operation code (mdu_pkg encodings)
//   src_a     forwarded rs value
//   src_b     forwarded rt value
//   busy      multi-cycle op in flight
//   md_rdata  HI for MFHI, LO for MFLO, else 0
// Optional feature: define MDU_MADD_EN to enable MADD/MSUB.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [31:0]        src_a,
  input  logic [31:0]        src_b,
  output logic               busy,
  output logic [31:0]        md_rdata
);

  localparam logic [3:0] MultCnt = 4'(MULT_CYCLES);
  localparam logic [3:0] DivCnt  = 4'(DIV_CYCLES);

  mdu_state_e  r_state;
  mdu_state_e  w_state_d;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] r_pend;
  logic        r_keep;

  logic        w_accept;
  logic        w_is_multi;
  logic        w_launch;
  logic        w_commit;
  logic [3:0]  w_cycles;
  logic [63:0] w_result;
  logic        w_keep;

  always_comb begin
    w_is_multi = 1'b0;
    case (md_op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: w_is_multi = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MSUB:                   w_is_multi = 1'b1;
`endif
      default:                            w_is_multi = 1'b0;
    endcase
  end

  // Starts are only honoured in idle, so launch and commit never coincide.
  assign w_accept = start && (r_state == StIdle);
  assign w_launch = w_accept && w_is_multi;
  assign w_commit = (r_state == StRun) && (r_cnt == 4'd1);
  assign w_cycles = is_div_op(md_op) ? DivCnt : MultCnt;

  mdu_compute u_compute (
    .i_op     (md_op),
    .i_a      (src_a),
    .i_b      (src_b),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .o_result (w_result),
    .o_keep   (w_keep)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  // FSM: next state
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_launch) w_state_d = StRun;
      StRun:   if (w_commit) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy     = (r_state == StRun);
    md_rdata = 32'd0;
    if (md_op == MD_MFHI)      md_rdata = r_hi;
    else if (md_op == MD_MFLO) md_rdata = r_lo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= 4'd0;
      r_pend <= 64'd0;
      r_keep <= 1'b0;
    end else if (w_launch) begin
      r_cnt  <= w_cycles;
      r_pend <= w_result;
      r_keep <= w_keep;
    end else if (r_state == StRun) begin
      r_cnt  <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      if (!r_keep) begin
        r_hi <= r_pend[63:32];
        r_lo <= r_pend[31:0];
      end
    end else if (w_accept) begin
      if (md_op == MD_MTHI) r_hi <= src_a;
      if (md_op == MD_MTLO) r_lo <= src_a;
    end
  end

  // A real op arriving while busy is dropped; the hazard unit should have stalled it.
  a_no_start_while_busy : assert property (
    @(posedge clk) disable iff (reset) !(start && busy && (md_op != MD_NONE))
  ) else $warning("mult_div_unit: start while busy ignored (op %0d)", md_op);

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int unsigned MultCycles = 5;
  localparam int unsigned DivCycles  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] md_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model state
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  always #5 clk = ~clk;

  mult_div_unit #(
    .MULT_CYCLES (MultCycles),
    .DIV_CYCLES  (DivCycles)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .busy     (busy),
    .md_rdata (md_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Applies an op to the model; returns the number of busy cycles it should produce.
  function automatic int model_apply(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          p;
    longint          q;
    longint          r;
    longint unsigned u;
    logic [63:0]     acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin p = sa * sb; {m_hi, m_lo} = p; return MultCycles; end
      4'd2: begin u = longint'({32'd0, a}) * longint'({32'd0, b}); {m_hi, m_lo} = u;
                  return MultCycles; end
      4'd3: begin
        if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
        return DivCycles;
      end
      4'd4: begin
        if (b != 0) begin m_lo = a / b; m_hi = a % b; end
        return DivCycles;
      end
      4'd5: begin m_hi = a; return 0; end
      4'd6: begin m_lo = a; return 0; end
`ifdef MDU_MADD_EN
      4'd9:  begin acc = {m_hi, m_lo} + 64'(sa * sb); {m_hi, m_lo} = acc; return MultCycles; end
      4'd10: begin acc = {m_hi, m_lo} - 64'(sa * sb); {m_hi, m_lo} = acc; return MultCycles; end
`endif
      default: return 0;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    md_op = MD_NONE;
    src_a = '0;
    src_b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
  endtask

  // Reads HI/LO via MFHI/MFLO within the current cycle and compares with the model.
  task automatic read_hilo(input string tag);
    md_op = MD_MFHI;
    #1 check_eq({tag, "_hi"}, {32'd0, md_rdata}, {32'd0, m_hi});
    md_op = MD_MFLO;
    #1 check_eq({tag, "_lo"}, {32'd0, md_rdata}, {32'd0, m_lo});
    md_op = MD_NONE;
  endtask

  task automatic read_lit(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    md_op = MD_MFHI;
    #1 check_eq({tag, "_hi_lit"}, {32'd0, md_rdata}, {32'd0, hi});
    md_op = MD_MFLO;
    #1 check_eq({tag, "_lo_lit"}, {32'd0, md_rdata}, {32'd0, lo});
    md_op = MD_NONE;
  endtask

  // Presents one op for one edge; returns #1 after that edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
    @(posedge clk);
    #1 start = 1'b0;
    md_op = MD_NONE;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int lat;
    int cnt;
    lat = model_apply(op, a, b);
    issue(op, a, b);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_busy_cycles"}, 64'(cnt), 64'(lat));
    read_hilo(tag);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cnt;
    do_reset();
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    read_hilo("rst");

    run_op("mthi", MD_MTHI, 32'h1234, 32'd0);
    read_lit("mthi", 32'h1234, 32'd0);

    run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3);
    read_lit("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    read_lit("multu", 32'hFFFF_FFFE, 32'h0000_0001);

    run_op("div", MD_DIV, -32'sd7, 32'd2);
    read_lit("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    run_op("divu_by0", MD_DIVU, 32'd7, 32'd0);
    read_lit("divu_by0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    read_lit("div_ovf", 32'd0, 32'h8000_0000);

    run_op("madd_hi", MD_MTHI, 32'd0, 32'd0);
    run_op("madd_lo", MD_MTLO, 32'd10, 32'd0);
    run_op("madd", MD_MADD, -32'sd2, 32'd3);
`ifdef MDU_MADD_EN
    read_lit("madd", 32'd0, 32'd4);
`else
    read_lit("madd", 32'd0, 32'd10);
`endif

    // DIVU presented while a MULT is running must be dropped.
    void'(model_apply(MD_MULT, 32'd6, 32'd7));
    issue(MD_MULT, 32'd6, 32'd7);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (busy) cnt++;
      if (i == 1) begin
        start = 1'b1;
        md_op = MD_DIVU;
        src_a = 32'd100;
        src_b = 32'd3;
      end
      @(posedge clk);
      #1 start = 1'b0;
      md_op = MD_NONE;
    end
    check_eq("ignored_start_busy", 64'(cnt), 64'(MultCycles));
    read_hilo("ignored_start");
    read_lit("ignored_start", 32'd0, 32'd42);

    // Reset in the third busy cycle of a MULT aborts it.
    issue(MD_MULT, 32'd5, 32'd5);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check_eq("abort_busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    check_eq("abort_busy_after", {63'd0, busy}, 64'd0);
    read_hilo("abort");
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) cnt++;
      @(posedge clk);
      #1;
    end
    check_eq("abort_no_late_busy", 64'(cnt), 64'd0);
    read_hilo("abort_late");

    for (int i = 0; i < 60; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 4'($urandom_range(0, 15));
      a  = pick_operand();
      b  = pick_operand();
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
